flit_transmitter: RTL
=====================

FLIT_TRANSMITTER -- requirements
Module: flit_transmitter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255: number of WAIT_ACK cycles without ack before a timeout.
REQ-002 Parameter MAX_RETRY, default 3: retransmissions allowed per flit before drop.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_flit  input  64  flit from router output stage.
REQ-006 i_flit_valid  input  1  i_flit valid.
REQ-007 o_flit_ready  output  1  transmitter can accept a flit.
REQ-008 o_byte  output  8  link byte.
REQ-009 o_byte_valid  output  1  o_byte valid.
REQ-010 i_byte_ready  input  1  link accepts o_byte.
REQ-011 i_ack  input  1  single-cycle pulse: receiver accepted the flit.
REQ-012 i_nack  input  1  single-cycle pulse: receiver rejected the flit.
REQ-013 o_sent  output  1  one-cycle pulse: flit acknowledged.
REQ-014 o_drop  output  1  one-cycle pulse: flit abandoned after retries.
REQ-015 o_retry_cnt  output  2  retransmissions done on the current flit; width SHALL be clog2(MAX_RETRY+1).

Function
REQ-016 FSM states SHALL be IDLE, SEND, WAIT_ACK.
REQ-017 o_flit_ready SHALL be 1 exactly when state is IDLE.
REQ-018 IDLE: i_flit_valid & o_flit_ready SHALL latch i_flit, clear byte index and retry count, go to SEND.
REQ-019 i_flit SHALL be ignored outside IDLE; latched flit is held until o_sent or o_drop.
REQ-020 SEND: o_byte_valid SHALL be 1; o_byte SHALL be latched-flit byte [63:56] at index 0, down to [7:0] at index 7 (MSB first).
REQ-021 SEND: index advances only on o_byte_valid & i_byte_ready; o_byte and index are held while i_byte_ready is 0.
REQ-022 Transfer of index 7 SHALL move to WAIT_ACK with the timeout counter cleared.
REQ-023 Latency: handshake in cycle N -> first byte valid in N+1; with i_byte_ready held 1, bytes occupy N+1..N+8 and WAIT_ACK starts in N+9.
REQ-024 WAIT_ACK: o_byte_valid SHALL be 0; the counter increments every cycle, saturating at ACK_TIMEOUT.
REQ-025 WAIT_ACK with i_ack=1: o_sent pulses next cycle; go to IDLE.
REQ-026 WAIT_ACK with i_nack=1, or counter==ACK_TIMEOUT, and no i_ack: if o_retry_cnt<MAX_RETRY, increment o_retry_cnt, clear index, go to SEND; else pulse o_drop next cycle and go to IDLE.
REQ-027 i_ack and i_nack together: i_ack wins. i_ack in the timeout cycle: i_ack wins.
REQ-028 i_ack/i_nack outside WAIT_ACK SHALL be ignored.
REQ-029 o_sent and o_drop SHALL be registered, never both high, each high for exactly one cycle per flit.
REQ-030 After o_sent/o_drop, IDLE (o_flit_ready=1) in the same cycle as the pulse; back-to-back flits are legal.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, o_byte_valid 0, o_byte 0, o_sent 0, o_drop 0, o_retry_cnt 0, counter 0, index 0, latched flit 0.
REQ-032 Reset mid-SEND or mid-WAIT_ACK SHALL abandon the flit without o_sent/o_drop; o_flit_ready=1 while rst_n=0 and after release.

Verification (bench: ACK_TIMEOUT=16, MAX_RETRY=2)
REQ-033 Flit 0x0123456789ABCDEF, i_byte_ready=1, i_ack 3 cycles into WAIT_ACK -> bytes 01,23,45,67,89,AB,CD,EF in consecutive cycles, one o_sent pulse, o_retry_cnt=0.
REQ-034 Same flit, i_byte_ready toggled 1/0 -> identical byte sequence, each byte held while not ready, 15 cycles total in SEND.
REQ-035 Flit 0xFFFF0000FFFF0000, i_nack at first WAIT_ACK, i_ack at second -> 16 bytes sent, o_retry_cnt=1, one o_sent, no o_drop.
REQ-036 No ack ever -> 3 transmissions of 8 bytes each, each WAIT_ACK lasting 17 cycles; then o_drop pulses once, o_retry_cnt=2, o_sent never high.
REQ-037 i_ack and i_nack asserted in the same WAIT_ACK cycle -> o_sent, no retransmission.
REQ-038 rst_n dropped after byte 4 -> o_byte_valid=0 immediately, no o_sent/o_drop; a new flit 0xA5A5A5A5A5A5A5A5 after release transmits from byte index 0.

Source files
------------

// File: rtl/flit_transmitter.sv
// Serialises 64-bit flits onto a byte link MSB first, then waits for ack/nack.
// A nack or an ack timeout retransmits the flit until the retry budget runs out.
module flit_transmitter #(
    parameter int ACK_TIMEOUT = 255,
    parameter int MAX_RETRY   = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [63:0]   i_flit,
    input  logic          i_flit_valid,
    output logic          o_flit_ready,
    output logic [7:0]    o_byte,
    output logic          o_byte_valid,
    input  logic          i_byte_ready,
    input  logic          i_ack,
    input  logic          i_nack,
    output logic          o_sent,
    output logic          o_drop,
    output logic [RW-1:0] o_retry_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [CW-1:0] CNT_MAX   = CW'(ACK_TIMEOUT);

    state_t        r_state;
    logic [63:0]   r_flit;
    logic [2:0]    r_idx;
    logic [RW-1:0] r_retry;
    logic [CW-1:0] r_cnt;
    logic          r_sent;
    logic          r_drop;

    state_t        w_state_nx;
    logic [63:0]   w_flit_nx;
    logic [2:0]    w_idx_nx;
    logic [RW-1:0] w_retry_nx;
    logic [CW-1:0] w_cnt_nx;
    logic          w_sent_nx;
    logic          w_drop_nx;
    logic [2:0]    w_sel;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_flit  <= 64'd0;
            r_idx   <= 3'd0;
            r_retry <= '0;
            r_cnt   <= '0;
            r_sent  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_flit  <= w_flit_nx;
            r_idx   <= w_idx_nx;
            r_retry <= w_retry_nx;
            r_cnt   <= w_cnt_nx;
            r_sent  <= w_sent_nx;
            r_drop  <= w_drop_nx;
        end
    end

    // Next-state logic; ack has priority over nack and over the timeout
    always_comb begin
        w_state_nx = r_state;
        w_flit_nx  = r_flit;
        w_idx_nx   = r_idx;
        w_retry_nx = r_retry;
        w_cnt_nx   = r_cnt;
        w_sent_nx  = 1'b0;
        w_drop_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_flit_valid) begin
                    w_flit_nx  = i_flit;
                    w_idx_nx   = 3'd0;
                    w_retry_nx = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_SEND;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (i_byte_ready) begin
                    w_idx_nx = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_cnt_nx   = '0;
                        w_state_nx = ST_WAIT_ACK;
                    end else begin
                        w_state_nx = ST_SEND;
                    end
                end else begin
                    w_state_nx = ST_SEND;
                end
            end
            ST_WAIT_ACK: begin
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nx = r_cnt + CW'(1);
                end else begin
                    w_cnt_nx = r_cnt;
                end
                if (i_ack) begin
                    w_sent_nx  = 1'b1;
                    w_state_nx = ST_IDLE;
                end else if (i_nack || (r_cnt == CNT_MAX)) begin
                    if (r_retry < RETRY_MAX) begin
                        w_retry_nx = r_retry + RW'(1);
                        w_idx_nx   = 3'd0;
                        w_state_nx = ST_SEND;
                    end else begin
                        w_drop_nx  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_state_nx = ST_WAIT_ACK;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Byte lane select: index 0 is the most significant byte
    always_comb begin
        w_sel = 3'd7 - r_idx;
        if (r_state == ST_SEND) begin
            o_byte = r_flit[{w_sel, 3'b000} +: 8];
        end else begin
            o_byte = 8'd0;
        end
    end

    assign o_flit_ready = (r_state == ST_IDLE);
    assign o_byte_valid = (r_state == ST_SEND);
    assign o_sent       = r_sent;
    assign o_drop       = r_drop;
    assign o_retry_cnt  = r_retry;

endmodule
